// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Bridges the EX/MEM pipeline register and the word-addressed data
//            memory. Turns byte-addressed MIPS loads/stores (LB/LBU/LH/LHU/LW,
//            SB/SH/SW) into word accesses: sub-word stores run as
//            read-modify-write, loaded lanes are extracted and extended.
//            Illegal, misaligned and out-of-range requests are rejected with
//            an o_done/o_error pulse and no memory activity.
// Ports    : i_clk, i_reset (sync, active-low)
//            i_valid/i_MemRead/i_MemWrite/i_Tamano/i_Unsigned/i_Direccion/
//            i_DatoRegistro : request, sampled only while idle
//            i_MemDato      : word returned by memory, one cycle after read
//            o_MemDireccion/o_MemDato/o_MemRead/o_MemWrite : memory side
//            o_DatoCargado  : formatted load result (held until next load)
//            o_done/o_error : one-cycle completion pulses
//            o_busy         : high while a request is in flight
// Notes    : lane handling assumes 32-bit words of four little-endian bytes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_MemRead,
    input  logic             i_MemWrite,
    input  logic [1:0]       i_Tamano,
    input  logic             i_Unsigned,
    input  logic [NBITS-1:0] i_Direccion,
    input  logic [NBITS-1:0] i_DatoRegistro,
    input  logic [NBITS-1:0] i_MemDato,
    output logic [NBITS-1:0] o_MemDireccion,
    output logic [NBITS-1:0] o_MemDato,
    output logic             o_MemRead,
    output logic             o_MemWrite,
    output logic [NBITS-1:0] o_DatoCargado,
    output logic             o_done,
    output logic             o_error,
    output logic             o_busy
);

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_RD   = 3'd1;
    localparam logic [2:0] C_ST_CAP  = 3'd2;
    localparam logic [2:0] C_ST_MRG  = 3'd3;
    localparam logic [2:0] C_ST_WR   = 3'd4;
    localparam logic [2:0] C_ST_ERR  = 3'd5;

    localparam logic [1:0] C_SZ_BYTE = 2'b00;
    localparam logic [1:0] C_SZ_HALF = 2'b01;
    localparam logic [1:0] C_SZ_WORD = 2'b11;

    localparam logic [NBITS-1:0] C_CELDAS    = NBITS'(CELDAS);
    localparam logic [NBITS-1:0] C_BYTE_MASK = {{(NBITS-8){1'b0}}, 8'hFF};
    localparam logic [NBITS-1:0] C_HALF_MASK = {{(NBITS-16){1'b0}}, 16'hFFFF};

    logic [2:0]       state_q, state_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;    // store data, later the merged word
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             load_q, load_d;
    logic [NBITS-1:0] dato_q, dato_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             w_illegal;
    logic             w_misalign;
    logic             w_range;
    logic [4:0]       w_lane_sh;
    logic [NBITS-1:0] w_lane_mask;
    logic [NBITS-1:0] w_merged;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [NBITS-1:0] w_load_val;

    // Request checks, evaluated on the live inputs at the accept edge.
    assign w_illegal  = (i_MemRead == i_MemWrite) || (i_Tamano == 2'b10);
    assign w_misalign = ((i_Tamano == C_SZ_HALF) && i_Direccion[0]) ||
                        ((i_Tamano == C_SZ_WORD) && (i_Direccion[1:0] != 2'b00));
    assign w_range    = (i_Direccion >> 2) >= C_CELDAS;

    // Bit offset of the addressed lane inside the word.
    assign w_lane_sh   = (size_q == C_SZ_BYTE) ? {addr_q[1:0], 3'b000}
                                               : {addr_q[1], 4'b0000};
    assign w_lane_mask = ((size_q == C_SZ_BYTE) ? C_BYTE_MASK : C_HALF_MASK) << w_lane_sh;
    // Keep the other lanes of the memory word, drop the store data into ours.
    assign w_merged    = (i_MemDato & ~w_lane_mask) | ((wdata_q << w_lane_sh) & w_lane_mask);

    always_comb begin
        w_byte = i_MemDato[7:0];
        case (addr_q[1:0])
            2'd0:    w_byte = i_MemDato[7:0];
            2'd1:    w_byte = i_MemDato[15:8];
            2'd2:    w_byte = i_MemDato[23:16];
            default: w_byte = i_MemDato[NBITS-1:24];
        endcase
    end

    assign w_half = addr_q[1] ? i_MemDato[NBITS-1:16] : i_MemDato[15:0];

    always_comb begin
        w_load_val = i_MemDato;
        case (size_q)
            C_SZ_BYTE: w_load_val = uns_q ? {{(NBITS-8){1'b0}}, w_byte}
                                          : {{(NBITS-8){w_byte[7]}}, w_byte};
            C_SZ_HALF: w_load_val = uns_q ? {{(NBITS-16){1'b0}}, w_half}
                                          : {{(NBITS-16){w_half[15]}}, w_half};
            default:   w_load_val = i_MemDato;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        load_d  = load_q;
        dato_d  = dato_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (i_valid) begin
                    addr_d  = i_Direccion;
                    wdata_d = i_DatoRegistro;
                    size_d  = i_Tamano;
                    uns_d   = i_Unsigned;
                    load_d  = i_MemRead;
                    if (w_illegal || w_misalign || w_range) begin
                        state_d = C_ST_ERR;
                    end else if (i_MemRead) begin
                        state_d = C_ST_RD;
                    end else if (i_Tamano == C_SZ_WORD) begin
                        state_d = C_ST_WR;       // full word: no read needed
                    end else begin
                        state_d = C_ST_RD;       // sub-word store: read first
                    end
                end
            end
            C_ST_RD: begin
                state_d = load_q ? C_ST_CAP : C_ST_MRG;
            end
            C_ST_CAP: begin
                dato_d  = w_load_val;
                done_d  = 1'b1;
                state_d = C_ST_IDLE;
            end
            C_ST_MRG: begin
                wdata_d = w_merged;
                state_d = C_ST_WR;
            end
            C_ST_WR: begin
                done_d  = 1'b1;
                state_d = C_ST_IDLE;
            end
            C_ST_ERR: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= C_ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
            dato_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            load_q  <= load_d;
            dato_q  <= dato_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Memory-side outputs depend only on state and latched registers.
    assign o_MemDireccion = {2'b00, addr_q[NBITS-1:2]};
    assign o_MemDato      = wdata_q;
    assign o_MemRead      = (state_q == C_ST_RD);
    assign o_MemWrite     = (state_q == C_ST_WR);
    assign o_DatoCargado  = dato_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_busy         = (state_q != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A small data memory
//            model (read registered on posedge, write at negedge) answers the
//            DUT. A table of directed requests with hand-computed results is
//            applied back-to-back, followed by hand-written sequences for
//            held-valid back-to-back loads and reset during a store merge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [1:0]  i_Tamano;
    logic        i_Unsigned;
    logic [31:0] i_Direccion;
    logic [31:0] i_DatoRegistro;
    logic [31:0] i_MemDato;
    logic [31:0] o_MemDireccion;
    logic [31:0] o_MemDato;
    logic        o_MemRead;
    logic        o_MemWrite;
    logic [31:0] o_DatoCargado;
    logic        o_done;
    logic        o_error;
    logic        o_busy;

    int n_total = 0;
    int n_pass  = 0;

    mem_access_unit #(.NBITS(32), .CELDAS(10)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_valid        (i_valid),
        .i_MemRead      (i_MemRead),
        .i_MemWrite     (i_MemWrite),
        .i_Tamano       (i_Tamano),
        .i_Unsigned     (i_Unsigned),
        .i_Direccion    (i_Direccion),
        .i_DatoRegistro (i_DatoRegistro),
        .i_MemDato      (i_MemDato),
        .o_MemDireccion (o_MemDireccion),
        .o_MemDato      (o_MemDato),
        .o_MemRead      (o_MemRead),
        .o_MemWrite     (o_MemWrite),
        .o_DatoCargado  (o_DatoCargado),
        .o_done         (o_done),
        .o_error        (o_error),
        .o_busy         (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- data memory model ----------------
    logic [31:0] mem [0:9];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;
    logic        rd_pend;
    logic [31:0] rd_idx;

    always @(negedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (o_MemWrite && (o_MemDireccion < 32'd10)) begin
            mem[o_MemDireccion[3:0]] <= o_MemDato;
        end
        rd_pend <= o_MemRead;
        rd_idx  <= o_MemDireccion;
    end

    always @(posedge clk) begin
        if (rd_pend) begin
            i_MemDato <= (rd_idx < 32'd10) ? mem[rd_idx[3:0]] : 32'h0;
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = 4'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        @(negedge clk);
        #1;
        pl_en  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        mr;
        logic        mw;
        logic [1:0]  tam;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;      // cycles from accept edge to o_done cycle
        logic        err;
        logic        rd;       // read enable expected at some point
        logic        wr;       // write enable expected at some point
        logic [31:0] idx;      // expected word index on memory port
        logic [31:0] wdat;     // expected o_MemDato in WR cycle
        logic [31:0] dato;     // expected o_DatoCargado in done cycle
    } vec_t;

    function automatic vec_t mk(input logic mr, input logic mw, input logic [1:0] tam,
                                input logic uns, input logic [31:0] addr, input logic [31:0] data,
                                input int lat, input logic err, input logic rd, input logic wr,
                                input logic [31:0] idx, input logic [31:0] wdat,
                                input logic [31:0] dato);
        vec_t v;
        v.mr = mr; v.mw = mw; v.tam = tam; v.uns = uns; v.addr = addr; v.data = data;
        v.lat = lat; v.err = err; v.rd = rd; v.wr = wr; v.idx = idx; v.wdat = wdat;
        v.dato = dato;
        return v;
    endfunction

    // Issue one request from the current cycle and follow it to o_done.
    task automatic run_req(input vec_t v, output int lat, output logic err,
                           output logic [31:0] dato, output logic saw_rd, output logic saw_wr,
                           output logic [31:0] idx, output logic [31:0] wdat);
        i_valid        = 1'b1;
        i_MemRead      = v.mr;
        i_MemWrite     = v.mw;
        i_Tamano       = v.tam;
        i_Unsigned     = v.uns;
        i_Direccion    = v.addr;
        i_DatoRegistro = v.data;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = -1; err = 1'b0; dato = 32'h0; saw_rd = 1'b0; saw_wr = 1'b0;
        idx = 32'h0; wdat = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            if (o_MemRead) begin
                saw_rd = 1'b1;
                idx    = o_MemDireccion;
            end
            if (o_MemWrite) begin
                saw_wr = 1'b1;
                idx    = o_MemDireccion;
                wdat   = o_MemDato;
            end
            if (o_done) begin
                lat  = k;
                err  = o_error;
                dato = o_DatoCargado;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t vt [22];

    initial begin : main
        int          lat;
        logic        err, srd, swr;
        logic [31:0] dato, idx, wdat;
        int          d1, d2, ndone, nwr;
        logic [31:0] v1, v2;
        logic [31:0] init_mem [10];

        i_reset = 1'b0; i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
        i_Tamano = 2'b00; i_Unsigned = 1'b0; i_Direccion = 32'h0; i_DatoRegistro = 32'h0;
        pl_en = 1'b0; pl_idx = 4'h0; pl_val = 32'h0;

        // LB/LH/LW/SB/SH/SW, errors, index boundary. Expected values worked by hand.
        vt[0]  = mk(1,0,2'b00,0, 32'd20, 32'h0,        3,0,1,0, 32'd5, 32'h0,        32'hFFFFFF86);
        vt[1]  = mk(1,0,2'b00,1, 32'd20, 32'h0,        3,0,1,0, 32'd5, 32'h0,        32'h00000086);
        vt[2]  = mk(1,0,2'b01,0, 32'd22, 32'h0,        3,0,1,0, 32'd5, 32'h0,        32'hFFFFF0FF);
        vt[3]  = mk(1,0,2'b01,1, 32'd22, 32'h0,        3,0,1,0, 32'd5, 32'h0,        32'h0000F0FF);
        vt[4]  = mk(1,0,2'b11,1, 32'd20, 32'h0,        3,0,1,0, 32'd5, 32'h0,        32'hF0FF8F86);
        vt[5]  = mk(0,1,2'b00,0, 32'd5,  32'h123456AB, 4,0,1,1, 32'd1, 32'h0000AB0F, 32'hF0FF8F86);
        vt[6]  = mk(1,0,2'b11,0, 32'd4,  32'h0,        3,0,1,0, 32'd1, 32'h0,        32'h0000AB0F);
        vt[7]  = mk(0,1,2'b11,0, 32'd8,  32'hDEADBEEF, 2,0,0,1, 32'd2, 32'hDEADBEEF, 32'h0000AB0F);
        vt[8]  = mk(0,1,2'b01,0, 32'd10, 32'h0000CAFE, 4,0,1,1, 32'd2, 32'hCAFEBEEF, 32'h0000AB0F);
        vt[9]  = mk(1,0,2'b11,0, 32'd8,  32'h0,        3,0,1,0, 32'd2, 32'h0,        32'hCAFEBEEF);
        vt[10] = mk(1,0,2'b01,0, 32'd3,  32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[11] = mk(1,0,2'b11,0, 32'd6,  32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[12] = mk(1,0,2'b11,0, 32'd40, 32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[13] = mk(1,1,2'b11,0, 32'd0,  32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[14] = mk(0,0,2'b11,0, 32'd0,  32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[15] = mk(1,0,2'b10,0, 32'd0,  32'h0,        2,1,0,0, 32'd0, 32'h0,        32'hCAFEBEEF);
        vt[16] = mk(1,0,2'b11,0, 32'd36, 32'h0,        3,0,1,0, 32'd9, 32'h0,        32'h13579BDF);
        vt[17] = mk(1,0,2'b00,0, 32'd39, 32'h0,        3,0,1,0, 32'd9, 32'h0,        32'h00000013);
        vt[18] = mk(1,0,2'b00,0, 32'd37, 32'h0,        3,0,1,0, 32'd9, 32'h0,        32'hFFFFFF9B);
        vt[19] = mk(0,1,2'b00,0, 32'd3,  32'h000000FF, 4,0,1,1, 32'd0, 32'hFF000000, 32'hFFFFFF9B);
        vt[20] = mk(1,0,2'b01,1, 32'd2,  32'h0,        3,0,1,0, 32'd0, 32'h0,        32'h0000FF00);
        vt[21] = mk(1,0,2'b01,0, 32'd2,  32'h0,        3,0,1,0, 32'd0, 32'h0,        32'hFFFFFF00);

        for (int i = 0; i < 10; i++) init_mem[i] = 32'h0;
        init_mem[1] = 32'h0000000F;
        init_mem[5] = 32'hF0FF8F86;
        init_mem[9] = 32'h13579BDF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",    {31'h0, o_busy},     32'h0);
        chk("reset_done",    {31'h0, o_done},     32'h0);
        chk("reset_error",   {31'h0, o_error},    32'h0);
        chk("reset_rd_wr",   {30'h0, o_MemRead, o_MemWrite}, 32'h0);
        chk("reset_dato",    o_DatoCargado,       32'h0);
        chk("reset_memdir",  o_MemDireccion,      32'h0);

        for (int i = 0; i < 10; i++) preload(i, init_mem[i]);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: each request is issued in the previous one's done cycle.
        for (int i = 0; i < 22; i++) begin
            run_req(vt[i], lat, err, dato, srd, swr, idx, wdat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_error", i),   {31'h0, err}, {31'h0, vt[i].err});
            chk($sformatf("v%0d_rd_seen", i), {31'h0, srd}, {31'h0, vt[i].rd});
            chk($sformatf("v%0d_wr_seen", i), {31'h0, swr}, {31'h0, vt[i].wr});
            if (vt[i].rd || vt[i].wr) chk($sformatf("v%0d_index", i), idx, vt[i].idx);
            if (vt[i].wr) chk($sformatf("v%0d_wdata", i), wdat, vt[i].wdat);
            if (vt[i].mr && !vt[i].mw) chk($sformatf("v%0d_dato", i), dato, vt[i].dato);
        end

        // Back-to-back loads with i_valid held: LB then (fields changed while busy) LBU.
        i_valid = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Tamano = 2'b00;
        i_Unsigned = 1'b0; i_Direccion = 32'd20; i_DatoRegistro = 32'h0;
        @(posedge clk);
        #1;
        i_Unsigned = 1'b1;
        d1 = -1; d2 = -1; v1 = 32'h0; v2 = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            if (o_done) begin
                if (d1 < 0) begin d1 = k; v1 = o_DatoCargado; end
                else if (d2 < 0) begin d2 = k; v2 = o_DatoCargado; end
            end
            if (k == 3) chk("b2b_busy_in_done", {31'h0, o_busy}, 32'h0);
            if (k == 4) begin
                chk("b2b_second_accepted", {31'h0, o_busy}, 32'h1);
                i_valid = 1'b0;
            end
            if (d2 >= 0) break;
            @(posedge clk);
            #1;
        end
        chk("b2b_first_done",  32'(d1), 32'd3);
        chk("b2b_first_dato",  v1, 32'hFFFFFF86);
        chk("b2b_second_done", 32'(d2), 32'd6);
        chk("b2b_second_dato", v2, 32'h00000086);

        // Reset during MRG of an SB: the store must be abandoned.
        i_valid = 1'b1; i_MemRead = 1'b0; i_MemWrite = 1'b1; i_Tamano = 2'b00;
        i_Unsigned = 1'b0; i_Direccion = 32'd4; i_DatoRegistro = 32'h00000055;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("rst_seq_rd", {31'h0, o_MemRead}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_seq_mrg_busy", {30'h0, o_busy, o_MemWrite}, 32'h2);
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_seq_outs", {28'h0, o_busy, o_done, o_MemRead, o_MemWrite}, 32'h0);
        chk("rst_seq_dato", o_DatoCargado, 32'h0);
        chk("rst_seq_mdato", o_MemDato, 32'h0);
        chk("rst_seq_mdir", o_MemDireccion, 32'h0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        ndone = 0; nwr = 0;
        for (int k = 0; k < 6; k++) begin
            if (o_done) ndone++;
            if (o_MemWrite) nwr++;
            @(posedge clk);
            #1;
        end
        chk("rst_seq_no_done", 32'(ndone), 32'd0);
        chk("rst_seq_no_write", 32'(nwr), 32'd0);
        run_req(mk(1,0,2'b11,0, 32'd4, 32'h0, 3,0,1,0, 32'd1, 32'h0, 32'h0000AB0F),
                lat, err, dato, srd, swr, idx, wdat);
        chk("post_rst_lw_latency", 32'(lat), 32'd3);
        chk("post_rst_lw_error", {31'h0, err}, 32'h0);
        chk("post_rst_lw_dato", dato, 32'h0000AB0F);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
